dm_hs: RTL and testbench
========================

// Module: dm_hs
// PURPOSE
//  Parametrised handshake data memory; successor to the fixed 4096-word single-cycle DM.
//  Accepts one load/store per req_valid/req_ready handshake and responds after LATENCY cycles.
//  Loads are sign/zero-extended; misaligned and out-of-range accesses return errors.
//  Clears its array with a post-reset sweep FSM. Sits at the MEM stage of the pipeline,
//  and the stall logic uses req_ready/rsp_valid.
// PARAMETERS
//  ADDR_W          12  word-address bits; DEPTH = 2**ADDR_W words of 32 bits
//  LATENCY          1  cycles from accept edge to response edge, for legal accesses (>=1)
//  CLEAR_ON_RESET   1  1: sweep-clear all words after reset; 0: skip the sweep
// PORTS
//  clk            in   1   clock; all state updates on the rising edge
//  reset          in   1   asynchronous, active-low reset
//  req_valid      in   1   request present
//  req_ready      out  1   block can accept; high only in IDLE
//  req_we         in   1   1 = store, 0 = load
//  req_size       in   2   0 byte, 1 half, 2 word, 3 illegal
//  req_unsigned   in   1   load zero-extends (lbu/lhu) when 1; ignored for stores and words
//  req_addr       in   32  byte address
//  req_wdata      in   32  store data; data sits in the low bits for sb/sh
//  req_pc         in   32  PC of the requesting instruction, used for the store log
//  rsp_valid      out  1   one-cycle response strobe
//  rsp_rdata      out  32  extended load data; 0 for stores and errors
//  rsp_err        out  1   qualifies rsp_valid: access was misaligned, out of range or illegal size
//  init_busy      out  1   clear sweep in progress
// BEHAVIOUR
//  Reset (reset==0, async):
//   - state=INIT, clr_ptr=0, wait count=0
//   - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_busy=1
//   - a transaction in flight is dropped and its pending store is never written
//  INIT:
//   - writes 0 to word clr_ptr each cycle and increments clr_ptr
//   - after word DEPTH-1: ->IDLE, init_busy=0
//   - CLEAR_ON_RESET=0: ->IDLE at the first edge after reset release; array keeps its contents
//  IDLE:
//   - req_ready=1
//   - accept at edge E0 when req_valid&&req_ready; latch all req_* fields
//   - error if any of: size==3; size==1 && addr[0]; size==2 && addr[1:0]!=0;
//     addr[31:ADDR_W+2]!=0
//   - error -> RESP at E0+1 with rsp_err=1, no memory write, latency independent of LATENCY
//   - legal -> WAIT; counter loaded with LATENCY-1; LATENCY=1 goes straight to RESP
//  WAIT: decrements the counter; ->RESP when it reaches 0, so the response edge is E0+LATENCY
//  RESP:
//   - rsp_valid high for exactly one cycle, then ->IDLE
//   - next accept possible at E0+LATENCY+1
//   - store commit happens on the edge entering RESP; a load in the same response sees it
//  Stores, byte enables from addr[1:0]:
//   - sb: BE=0001<<a; byte replicated across all lanes
//   - sh: BE=0011 if a[1]=0, else 1100; halfword replicated
//   - sw: BE=1111
//   - lanes with BE=0 keep their old value
//   - at commit, $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2],2'b00}, new_word)
//  Loads:
//   - word = mem[addr[ADDR_W+1:2]]
//   - byte lane = addr[1:0]; half lane = addr[1]
//   - sign-extend unless req_unsigned
//  Req inputs are ignored outside IDLE; the latched copy is used throughout.
// STRUCTURE
//  dm_pkg:
//   - SIZE_B/SIZE_H/SIZE_W/SIZE_X encodings
//   - state encodings INIT/IDLE/WAIT/RESP
//   - be_t (4-bit) typedef
//  dm_lane (combinational sub-module): BE generation, store-lane merge, load extract and extend.
//  dm_hs: FSM, clear pointer, latency counter, array, response registers, log.
// TESTING
//  1. Reset release, CLEAR_ON_RESET=1, ADDR_W=4
//     -> init_busy high for exactly 16 cycles; req_ready rises the next cycle; lw of any addr returns 0.
//  2. sw 0x12345678 @0x8, then lb @0x9, lbu @0xB, lh @0xA
//     -> rdata 0x00000056, 0x00000012, 0x00001234; log line shows *00000008 <= 12345678.
//  3. sb 0x80 @0x5 over a word holding 0
//     -> word=0x00008000; lb @0x5 -> 0xFFFFFF80; lbu @0x5 -> 0x00000080.
//  4. LATENCY=3, accept lw at E0
//     -> rsp_valid only at E0+3 for one cycle; req_ready low until E0+4.
//  5. sh @0x3, sw @0x2, lw @(DEPTH*4), size=3
//     -> each gives rsp_err=1 at E0+1, rdata=0, memory unchanged.
//  6. Assert reset during WAIT of sw @0x0 (LATENCY=4)
//     -> outputs return to reset values immediately; after the sweep, lw @0x0 returns 0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared encodings for the handshake data memory: access sizes, FSM states,
// byte-enable type and the access legality check.
package dm_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_X = 2'd3;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef logic [3:0] be_t;

    // Size/alignment part of the error check; the range check needs ADDR_W.
    function automatic logic bad_align(input logic [1:0] size, input logic [1:0] lo);
        return (size == SIZE_X) ||
               ((size == SIZE_H) && lo[0]) ||
               ((size == SIZE_W) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/dm_lane.sv
// Byte-lane datapath: byte enables, store merge into the old word, and
// load lane extraction with sign/zero extension.
module dm_lane
    import dm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        zero_ext,
    input  logic [1:0]  byte_sel,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output be_t         be,
    output logic [31:0] new_word,
    output logic [31:0] load_data
);

    logic [31:0] rep;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        be  = '0;
        rep = wdata;
        case (size)
            SIZE_B: begin
                be  = be_t'(4'b0001 << byte_sel);
                rep = {4{wdata[7:0]}};
            end
            SIZE_H: begin
                be  = byte_sel[1] ? 4'b1100 : 4'b0011;
                rep = {2{wdata[15:0]}};
            end
            SIZE_W: be = 4'b1111;
            default: be = '0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign new_word[8*gi +: 8] = be[gi] ? rep[8*gi +: 8] : old_word[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        byte_val  = old_word[8*byte_sel +: 8];
        half_val  = byte_sel[1] ? old_word[31:16] : old_word[15:0];
        load_data = '0;
        case (size)
            SIZE_B: load_data = zero_ext ? {24'b0, byte_val} : {{24{byte_val[7]}}, byte_val};
            SIZE_H: load_data = zero_ext ? {16'b0, half_val} : {{16{half_val[15]}}, half_val};
            SIZE_W: load_data = old_word;
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/dm_hs.sv
// Handshake data memory: one load/store per req_valid/req_ready handshake,
// response LATENCY cycles later, array cleared by a post-reset sweep.
module dm_hs
    import dm_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int LATENCY        = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        init_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   clr_ptr_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                we_reg, uns_reg, err_reg;
    logic [1:0]          size_reg;
    logic [31:0]         addr_reg, wdata_reg, pc_reg, rdata_reg;

    logic [31:0]         mem [DEPTH];

    logic                accept, req_err, finish, store_commit;
    logic [ADDR_W-1:0]   word_idx;
    logic [31:0]         old_word, new_word, load_data;
    be_t                 be;

    assign accept   = req_valid && (state_reg == IDLE);
    assign req_err  = bad_align(req_size, req_addr[1:0]) || (req_addr[31:ADDR_W+2] != '0);
    assign word_idx = addr_reg[ADDR_W+1:2];
    assign old_word = mem[word_idx];
    // The edge that leaves WAIT with a zero count is the response edge.
    assign finish       = (state_reg == WAIT) && (cnt_reg == '0);
    assign store_commit = finish && !err_reg && we_reg;

    dm_lane u_lane (
        .size     (size_reg),
        .zero_ext (uns_reg),
        .byte_sel (addr_reg[1:0]),
        .wdata    (wdata_reg),
        .old_word (old_word),
        .be       (be),
        .new_word (new_word),
        .load_data(load_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= INIT;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            INIT: if ((CLEAR_ON_RESET == 0) || (&clr_ptr_reg)) state_next = IDLE;
            IDLE: if (accept) state_next = WAIT;
            WAIT: if (cnt_reg == '0) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = INIT;
        endcase
    end

    always_comb begin
        req_ready = (state_reg == IDLE);
        rsp_valid = (state_reg == RESP);
        init_busy = (state_reg == INIT);
        rsp_err   = (state_reg == RESP) && err_reg;
        rsp_rdata = (state_reg == RESP) ? rdata_reg : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_ptr_reg <= '0;
            cnt_reg     <= '0;
            we_reg      <= 1'b0;
            uns_reg     <= 1'b0;
            err_reg     <= 1'b0;
            size_reg    <= SIZE_B;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            pc_reg      <= '0;
            rdata_reg   <= '0;
        end else begin
            if (state_reg == INIT) clr_ptr_reg <= clr_ptr_reg + ADDR_W'(1);
            if (accept) begin
                we_reg    <= req_we;
                uns_reg   <= req_unsigned;
                size_reg  <= req_size;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
                pc_reg    <= req_pc;
                err_reg   <= req_err;
                // Errors respond one edge after accept regardless of LATENCY.
                cnt_reg   <= req_err ? '0 : CNT_W'(LATENCY - 1);
            end else if ((state_reg == WAIT) && (cnt_reg != '0)) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
            if (finish) rdata_reg <= (!err_reg && !we_reg) ? load_data : '0;
        end
    end

    // Writes are gated by reset so an in-flight store is dropped when reset hits.
    always_ff @(posedge clk) begin
        if (reset) begin
            if ((state_reg == INIT) && (CLEAR_ON_RESET != 0)) mem[clr_ptr_reg] <= '0;
            else if (store_commit)                            mem[word_idx]    <= new_word;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset && store_commit)
            $display("%d@%h: *%h <= %h", $time, pc_reg, {addr_reg[31:2], 2'b00}, new_word);
    end
`endif

endmodule

// File: tb/tb_dm_hs.sv
// Directed bench for dm_hs: four instances cover LATENCY 1/3/4 and both sweep modes.
module tb_dm_hs;
    import dm_pkg::*;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic [3:0]  rst = 4'b0000;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = SIZE_W;
    logic [31:0] req_addr = '0, req_wdata = '0, req_pc = '0;
    logic        ready [4];
    logic        valid [4];
    logic        err   [4];
    logic        busy  [4];
    logic [31:0] rdata [4];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    dm_hs #(.ADDR_W(4), .LATENCY(1), .CLEAR_ON_RESET(1)) u_dut0 (
        .clk(clk), .reset(rst[0]), .req_valid(req_valid), .req_ready(ready[0]),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .rsp_valid(valid[0]), .rsp_rdata(rdata[0]), .rsp_err(err[0]), .init_busy(busy[0]));
    dm_hs #(.ADDR_W(4), .LATENCY(3), .CLEAR_ON_RESET(1)) u_dut1 (
        .clk(clk), .reset(rst[1]), .req_valid(req_valid), .req_ready(ready[1]),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .rsp_valid(valid[1]), .rsp_rdata(rdata[1]), .rsp_err(err[1]), .init_busy(busy[1]));
    dm_hs #(.ADDR_W(4), .LATENCY(4), .CLEAR_ON_RESET(1)) u_dut2 (
        .clk(clk), .reset(rst[2]), .req_valid(req_valid), .req_ready(ready[2]),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .rsp_valid(valid[2]), .rsp_rdata(rdata[2]), .rsp_err(err[2]), .init_busy(busy[2]));
    dm_hs #(.ADDR_W(4), .LATENCY(4), .CLEAR_ON_RESET(0)) u_dut3 (
        .clk(clk), .reset(rst[3]), .req_valid(req_valid), .req_ready(ready[3]),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .rsp_valid(valid[3]), .rsp_rdata(rdata[3]), .rsp_err(err[3]), .init_busy(busy[3]));

    // Releases reset of instance d at a falling edge and counts cycles with init_busy high.
    task automatic bring_up(input int d, output int nbusy);
        nbusy = 0;
        rst[d] = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (busy[d] !== 1'b1) break;
            nbusy++;
            @(negedge clk);
        end
    endtask

    // Presents one request and returns at the falling edge right after the accept edge.
    task automatic start_req(input int d, input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        for (int k = 0; k < 100 && ready[d] !== 1'b1; k++) @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_pc = req_pc + 32'd4;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_we = 1'b0; req_size = SIZE_X; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hDEAD_DEAD;
    endtask

    // Full transaction: lat = edges from accept to response edge (-1 on timeout),
    // nvalid = cycles rsp_valid was high, nlow = cycles req_ready stayed low after accept.
    task automatic xact(input int d, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int nvalid, output int nlow);
        lat = -1; nvalid = 0; nlow = 0; rd = 'x; er = 1'bx;
        start_req(d, we, size, uns, addr, wdata);
        for (int k = 1; k <= 60; k++) begin
            if (valid[d] === 1'b1) begin
                if (nvalid == 0) begin
                    lat = k - 1; rd = rdata[d]; er = err[d];
                end
                nvalid++;
            end
            if (ready[d] === 1'b1) break;
            nlow++;
            @(negedge clk);
        end
        $display("dut%0d we=%0d size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h err=%b lat=%0d",
                 d, we, size, uns, addr, wdata, rd, er, lat);
    endtask

    task automatic test_reset;
        int nb, lat, nv, nl;
        logic [31:0] rd;
        logic er;
        repeat (3) @(negedge clk);
        checks++;
        if ({ready[0], valid[0], err[0], busy[0], rdata[0]} !== {4'b0001, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs: ready/valid/err/busy/rdata=%b%b%b%b/%h, required 0001/00000000",
                     ready[0], valid[0], err[0], busy[0], rdata[0]);
        end
        bring_up(0, nb);
        checks++;
        if (nb != 16) begin
            errors++; $display("FAIL init_busy_cycles: %0d, required 16", nb);
        end
        checks++;
        if (ready[0] !== 1'b1) begin
            errors++; $display("FAIL ready_after_sweep: %b, required 1", ready[0]);
        end
        for (int a = 0; a < 64; a += 20) begin
            xact(0, 1'b0, SIZE_W, 1'b0, 32'(a & ~3), 32'h0, rd, er, lat, nv, nl);
            checks++;
            if (rd !== 32'h0 || er !== 1'b0 || lat != 1) begin
                errors++; $display("FAIL swept_lw @%0h: rdata=%h err=%b lat=%0d, required 00000000 0 1",
                                   a & ~3, rd, er, lat);
            end
        end
    endtask

    task automatic test_store_load;
        vec_t v[6];
        int lat, nv, nl;
        logic [31:0] rd;
        logic er;
        v[0] = '{1'b1, SIZE_W, 1'b0, 32'h8, 32'h12345678, 32'h0, 1'b0};
        v[1] = '{1'b0, SIZE_B, 1'b0, 32'h9, 32'h0, 32'h00000056, 1'b0};
        v[2] = '{1'b0, SIZE_B, 1'b1, 32'hB, 32'h0, 32'h00000012, 1'b0};
        v[3] = '{1'b0, SIZE_H, 1'b0, 32'hA, 32'h0, 32'h00001234, 1'b0};
        v[4] = '{1'b0, SIZE_H, 1'b0, 32'h8, 32'h0, 32'h00005678, 1'b0};
        v[5] = '{1'b0, SIZE_W, 1'b0, 32'h8, 32'h0, 32'h12345678, 1'b0};
        foreach (v[i]) begin
            xact(0, v[i].we, v[i].size, v[i].uns, v[i].addr, v[i].wdata, rd, er, lat, nv, nl);
            checks++;
            if (rd !== v[i].exp_rd || er !== v[i].exp_err || lat != 1 || nv != 1) begin
                errors++; $display("FAIL store_load[%0d]: rdata=%h err=%b lat=%0d nvalid=%0d, required %h %b 1 1",
                                   i, rd, er, lat, nv, v[i].exp_rd, v[i].exp_err);
            end
        end
    endtask

    task automatic test_subword;
        vec_t v[8];
        int lat, nv, nl;
        logic [31:0] rd;
        logic er;
        v[0] = '{1'b1, SIZE_B, 1'b0, 32'h5, 32'hABCDEF80, 32'h0, 1'b0};
        v[1] = '{1'b0, SIZE_W, 1'b0, 32'h4, 32'h0, 32'h00008000, 1'b0};
        v[2] = '{1'b0, SIZE_B, 1'b0, 32'h5, 32'h0, 32'hFFFFFF80, 1'b0};
        v[3] = '{1'b0, SIZE_B, 1'b1, 32'h5, 32'h0, 32'h00000080, 1'b0};
        v[4] = '{1'b1, SIZE_H, 1'b0, 32'hE, 32'h1234BEEF, 32'h0, 1'b0};
        v[5] = '{1'b0, SIZE_H, 1'b0, 32'hE, 32'h0, 32'hFFFFBEEF, 1'b0};
        v[6] = '{1'b0, SIZE_H, 1'b1, 32'hE, 32'h0, 32'h0000BEEF, 1'b0};
        v[7] = '{1'b0, SIZE_W, 1'b0, 32'hC, 32'h0, 32'hBEEF0000, 1'b0};
        foreach (v[i]) begin
            xact(0, v[i].we, v[i].size, v[i].uns, v[i].addr, v[i].wdata, rd, er, lat, nv, nl);
            checks++;
            if (rd !== v[i].exp_rd || er !== v[i].exp_err || lat != 1) begin
                errors++; $display("FAIL subword[%0d]: rdata=%h err=%b lat=%0d, required %h %b 1",
                                   i, rd, er, lat, v[i].exp_rd, v[i].exp_err);
            end
        end
    endtask

    task automatic test_errors;
        vec_t v[7];
        int lat, nv, nl;
        logic [31:0] rd;
        logic er;
        v[0] = '{1'b1, SIZE_H, 1'b0, 32'h3,  32'hFFFFFFFF, 32'h0, 1'b1};
        v[1] = '{1'b1, SIZE_W, 1'b0, 32'h2,  32'hFFFFFFFF, 32'h0, 1'b1};
        v[2] = '{1'b1, SIZE_W, 1'b0, 32'h40, 32'hFFFFFFFF, 32'h0, 1'b1};
        v[3] = '{1'b1, SIZE_X, 1'b0, 32'h0,  32'hFFFFFFFF, 32'h0, 1'b1};
        v[4] = '{1'b0, SIZE_W, 1'b0, 32'h48, 32'h0, 32'h0, 1'b1};
        v[5] = '{1'b0, SIZE_W, 1'b0, 32'h0,  32'h0, 32'h0, 1'b0};
        v[6] = '{1'b0, SIZE_W, 1'b0, 32'h8,  32'h0, 32'h12345678, 1'b0};
        foreach (v[i]) begin
            xact(0, v[i].we, v[i].size, v[i].uns, v[i].addr, v[i].wdata, rd, er, lat, nv, nl);
            checks++;
            if (rd !== v[i].exp_rd || er !== v[i].exp_err || lat != 1) begin
                errors++; $display("FAIL errors[%0d]: rdata=%h err=%b lat=%0d, required %h %b 1",
                                   i, rd, er, lat, v[i].exp_rd, v[i].exp_err);
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat, nv, nl;
        logic [31:0] rd;
        logic er;
        xact(0, 1'b1, SIZE_W, 1'b0, 32'h3C, 32'hCAFEF00D, rd, er, lat, nv, nl);
        checks++;
        if (nl != 2 || nv != 1) begin
            errors++; $display("FAIL b2b_store_timing: ready_low=%0d nvalid=%0d, required 2 1", nl, nv);
        end
        xact(0, 1'b0, SIZE_W, 1'b0, 32'h3C, 32'h0, rd, er, lat, nv, nl);
        checks++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0 || lat != 1) begin
            errors++; $display("FAIL b2b_load: rdata=%h err=%b lat=%0d, required cafef00d 0 1", rd, er, lat);
        end
    endtask

    task automatic test_latency;
        int nb, lat, nv, nl;
        logic [31:0] rd;
        logic er;
        bring_up(1, nb);
        xact(1, 1'b1, SIZE_H, 1'b0, 32'h4, 32'h000055AA, rd, er, lat, nv, nl);
        checks++;
        if (lat != 3 || nv != 1 || nl != 4) begin
            errors++; $display("FAIL lat3_store: lat=%0d nvalid=%0d ready_low=%0d, required 3 1 4", lat, nv, nl);
        end
        xact(1, 1'b0, SIZE_W, 1'b0, 32'h4, 32'h0, rd, er, lat, nv, nl);
        checks++;
        if (rd !== 32'h000055AA || er !== 1'b0 || lat != 3 || nv != 1 || nl != 4) begin
            errors++; $display("FAIL lat3_load: rdata=%h err=%b lat=%0d nvalid=%0d ready_low=%0d, required 000055aa 0 3 1 4",
                               rd, er, lat, nv, nl);
        end
        xact(1, 1'b0, SIZE_H, 1'b0, 32'h1, 32'h0, rd, er, lat, nv, nl);
        checks++;
        if (rd !== 32'h0 || er !== 1'b1 || lat != 1 || nl != 2) begin
            errors++; $display("FAIL lat3_error: rdata=%h err=%b lat=%0d ready_low=%0d, required 00000000 1 1 2",
                               rd, er, lat, nl);
        end
    endtask

    task automatic test_reset_in_wait;
        int nb, lat, nv, nl;
        logic [31:0] rd;
        logic er;
        // Sweep-clearing instance: a store interrupted in WAIT must not survive.
        bring_up(2, nb);
        start_req(2, 1'b1, SIZE_W, 1'b0, 32'h0, 32'hFFFFFFFF);
        @(negedge clk);
        rst[2] = 1'b0;
        #1;
        checks++;
        if ({ready[2], valid[2], err[2], busy[2], rdata[2]} !== {4'b0001, 32'h0}) begin
            errors++; $display("FAIL reset_in_wait_outputs: ready/valid/err/busy/rdata=%b%b%b%b/%h, required 0001/00000000",
                               ready[2], valid[2], err[2], busy[2], rdata[2]);
        end
        repeat (6) @(negedge clk);
        bring_up(2, nb);
        xact(2, 1'b0, SIZE_W, 1'b0, 32'h0, 32'h0, rd, er, lat, nv, nl);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0 || lat != 4) begin
            errors++; $display("FAIL reset_in_wait_lw: rdata=%h err=%b lat=%0d, required 00000000 0 4", rd, er, lat);
        end
        // Non-clearing instance: the old word must be intact and the dropped store absent.
        bring_up(3, nb);
        checks++;
        if (nb != 1) begin
            errors++; $display("FAIL noclear_busy_cycles: %0d, required 1", nb);
        end
        xact(3, 1'b1, SIZE_W, 1'b0, 32'h0, 32'h11111111, rd, er, lat, nv, nl);
        start_req(3, 1'b1, SIZE_W, 1'b0, 32'h0, 32'h22222222);
        @(negedge clk);
        rst[3] = 1'b0;
        repeat (6) @(negedge clk);
        bring_up(3, nb);
        xact(3, 1'b0, SIZE_W, 1'b0, 32'h0, 32'h0, rd, er, lat, nv, nl);
        checks++;
        if (rd !== 32'h11111111 || er !== 1'b0 || lat != 4) begin
            errors++; $display("FAIL dropped_store: rdata=%h err=%b lat=%0d, required 11111111 0 4", rd, er, lat);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_subword();
        test_errors();
        test_back_to_back();
        test_latency();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
